rpn_stack_controller: RTL
=========================

# rpn_stack_controller

Sequencer that turns the reverse-Polish calculator's single-register ALU into a 4-deep operand-stack machine. It holds operands pushed with Enter and, on an Op command, drives the ALU system's load_A / load_B / load_Op / updateRes strobes through a fixed five-step sequence. It then replaces the two consumed operands with the ALU result. It sits between the edge detectors and the ALU system block and supplies the value shown on the display.

## Interface
Parameters:
- W, 16, operand/result width
- DEPTH, 4, stack entries (power of two, ≥2)
- OPW, 2, opcode width; opcode is driven on alu_data[OPW-1:0]

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0); one clock domain only
- enter_pulse  in  1  one-cycle pulse: push data_in
- op_pulse  in  1  one-cycle pulse: apply op_in to the two top entries
- undo_pulse  in  1  one-cycle pulse: undo (see Configuration)
- data_in  in  W  operand to push
- op_in  in  OPW  ALU opcode, sampled with op_pulse
- alu_result  in  W  ALU result, valid the cycle after updateRes
- alu_data  out  W  value driven to the ALU data input
- load_A, load_B, load_Op, updateRes  out  1 each  ALU strobes, one cycle each
- top  out  W  stack top, or 0 when empty
- depth  out  $clog2(DEPTH)+1  number of valid entries
- busy  out  1  high whenever the FSM is not in IDLE
- error  out  1  last command was rejected
- Status  out  3  state code

## Operation
- States and Status codes: IDLE=0, LOAD_A=1, LOAD_B=2, LOAD_OP=3, EXEC=4, WRITEBACK=5.
- Commands are accepted only in IDLE. Pulses arriving while busy are dropped, and error is not set.
- If several pulses arrive in the same cycle, exactly one is accepted. Priority: undo > op > enter.
- Enter:
  - depth<DEPTH: stack[depth]←data_in, depth+1, error←0.
  - depth==DEPTH: stack unchanged, error←1.
- Op:
  - depth<2: error←1, stay in IDLE.
  - Otherwise latch op_in, error←0, go to LOAD_A.
- Op sequence:
  - LOAD_A: alu_data=stack[depth-2], load_A=1.
  - LOAD_B: alu_data=stack[depth-1], load_B=1.
  - LOAD_OP: alu_data=zero-extended latched opcode, load_Op=1.
  - EXEC: updateRes=1.
  - WRITEBACK: stack[depth-2]←alu_result, depth−1, return to IDLE.
- Undo, basic: depth>0 pops the top entry and sets error←0. depth==0 sets error←1.
- alu_data is 0 in IDLE, EXEC and WRITEBACK. Strobes are 0 outside their own state.
- Arithmetic is performed entirely by the ALU. The controller never modifies values; results are W bits exactly as returned.

## Timing
- Reset asserted: immediately and asynchronously, all stack entries=0, depth=0, state=IDLE, every output=0. This includes reset during a sequence: the sequence is abandoned and nothing is written back.
- Enter or Undo pulse in cycle n: top, depth and error update at the clock edge ending cycle n, and are visible in cycle n+1.
- Op pulse in cycle n:
  - load_A in cycle n+1, load_B in n+2, load_Op in n+3, updateRes in n+4.
  - alu_result is sampled in n+5 (WRITEBACK).
  - New top and depth are visible in n+6, and busy falls in n+6.
  - Total latency is 6 cycles.
- The next command is accepted in cycle n+6 at the earliest.

## Configuration
- UNDO_RESTORE_EN defined:
  - WRITEBACK also saves the two consumed operands in shadow registers and sets restore_valid.
  - Undo with restore_valid=1: stack[depth-1]←shadow A, stack[depth]←shadow B, depth+1, restore_valid←0. This exactly reverses the last operation.
  - Any accepted Enter, Op or Undo clears restore_valid.
  - An Undo when restore_valid=0 behaves as a basic pop.
- UNDO_RESTORE_EN not defined: no shadow registers. Undo is always a basic pop.

## Structure
- Package rpn_ctrl_pkg holds:
  - the state enum, with the Status codes above
  - default W, DEPTH, OPW localparams
- Sub-module rpn_stack is the register array with push, pop and overwrite-second ports, plus depth and top outputs. The FSM, strobe decoding and undo shadow logic stay in rpn_stack_controller.

## Test plan
- Reset, then Enter 0x0005, Enter 0x0003 -> depth=2, top=0x0003, error=0.
- Op with op_in=0 (add), and the ALU model returning A+B -> strobes in cycles n+1..n+4, Status 1→2→3→4→5→0, top=0x0008, depth=1 in n+6.
- Five Enters on an empty stack -> depth=4 after the fourth, and the fifth sets error=1 with depth unchanged. Then Op with depth=1 (after three Undos) -> error=1 and load_A never asserted.
- undo_pulse and enter_pulse in the same cycle with depth=2 -> pop only, depth=1. Any pulse during busy -> ignored, error unchanged.
- UNDO_RESTORE_EN: push 0x0007 and 0x0002, Op subtract (result 0x0005), then Undo -> depth=2, stack = 0x0007, 0x0002. A second Undo -> depth=1, top=0x0007.
- reset driven low in the LOAD_B cycle -> all outputs 0 immediately. After release, depth=0 and no strobes occur.

Source files
------------

// File: rtl/rpn_ctrl_pkg.sv
// rpn_ctrl_pkg: shared state encoding and default sizing for the RPN stack controller.
package rpn_ctrl_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_OPW   = 2;

    // Encodings double as the externally visible Status code.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_A    = 3'd1,
        ST_LOAD_B    = 3'd2,
        ST_LOAD_OP   = 3'd3,
        ST_EXEC      = 3'd4,
        ST_WRITEBACK = 3'd5
    } state_t;

endpackage

// File: rtl/rpn_stack_controller_if.sv
// rpn_stack_controller_if: command inputs, ALU handshake and display/status outputs.
interface rpn_stack_controller_if
    import rpn_ctrl_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int OPW   = DEF_OPW
);
    logic                   enter_pulse;
    logic                   op_pulse;
    logic                   undo_pulse;
    logic [W-1:0]           data_in;
    logic [OPW-1:0]         op_in;
    logic [W-1:0]           alu_result;
    logic [W-1:0]           alu_data;
    logic                   load_A;
    logic                   load_B;
    logic                   load_Op;
    logic                   updateRes;
    logic [W-1:0]           top;
    logic [$clog2(DEPTH):0] depth;
    logic                   busy;
    logic                   error;
    logic [2:0]             Status;

    // Environment side: edge detectors, ALU system and display.
    modport master (
        output enter_pulse, op_pulse, undo_pulse, data_in, op_in, alu_result,
        input  alu_data, load_A, load_B, load_Op, updateRes, top, depth, busy, error, Status
    );

    // Controller side.
    modport slave (
        input  enter_pulse, op_pulse, undo_pulse, data_in, op_in, alu_result,
        output alu_data, load_A, load_B, load_Op, updateRes, top, depth, busy, error, Status
    );
endinterface

// File: rtl/rpn_stack.sv
// rpn_stack: operand register array with push, pop, overwrite-second and
// two-entry restore operations; exposes depth, top and the two top entries.
module rpn_stack
    import rpn_ctrl_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   wr_second,
    input  logic [W-1:0]           wr_data,
    input  logic                   restore,
    input  logic [W-1:0]           restore_a,
    input  logic [W-1:0]           restore_b,
    output logic [W-1:0]           rd_second,
    output logic [W-1:0]           rd_top,
    output logic [W-1:0]           top,
    output logic [$clog2(DEPTH):0] depth
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] idx_push;
    logic [AW-1:0] idx_top;
    logic [AW-1:0] idx_second;

    // Indices wrap modulo DEPTH, so a full stack still addresses its top correctly.
    assign idx_push   = depth[AW-1:0];
    assign idx_top    = idx_push - AW'(1);
    assign idx_second = idx_push - AW'(2);

    assign rd_top    = mem[idx_top];
    assign rd_second = mem[idx_second];
    assign top       = (depth == '0) ? '0 : rd_top;

    // Apply the single stack operation requested this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            depth <= '0;
        end else if (push) begin
            mem[idx_push] <= push_data;
            depth         <= depth + DW'(1);
        end else if (pop) begin
            depth <= depth - DW'(1);
        end else if (wr_second) begin
            mem[idx_second] <= wr_data;
            depth           <= depth - DW'(1);
        end else if (restore) begin
            mem[idx_top]  <= restore_a;
            mem[idx_push] <= restore_b;
            depth         <= depth + DW'(1);
        end
    end

endmodule

// File: rtl/rpn_stack_controller.sv
// rpn_stack_controller: sequences the single-register ALU as a stack machine.
// Optional feature macro: UNDO_RESTORE_EN (undo reverses the last operation).
module rpn_stack_controller
    import rpn_ctrl_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int OPW   = DEF_OPW
) (
    input logic                  clk,
    input logic                  reset,
    rpn_stack_controller_if.slave bus
);
    localparam int DW = $clog2(DEPTH) + 1;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic           error_q, error_d;
    logic           op_latch, accepted;
    logic           push, pop, wr_second, restore;
    logic [W-1:0]   rd_second, rd_top, top_w, alu_data_w;
    logic [DW-1:0]  depth_w;
    logic           la, lb, lo, ur;
    logic [W-1:0]   shadow_a, shadow_b;
    logic           restore_valid;

    rpn_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (bus.data_in),
        .pop       (pop),
        .wr_second (wr_second),
        .wr_data   (bus.alu_result),
        .restore   (restore),
        .restore_a (shadow_a),
        .restore_b (shadow_b),
        .rd_second (rd_second),
        .rd_top    (rd_top),
        .top       (top_w),
        .depth     (depth_w)
    );

    // Command arbitration (undo > op > enter) and the fixed five-step op sequence.
    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        op_latch   = 1'b0;
        accepted   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        wr_second  = 1'b0;
        restore    = 1'b0;
        alu_data_w = '0;
        la         = 1'b0;
        lb         = 1'b0;
        lo         = 1'b0;
        ur         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.undo_pulse) begin
                    accepted = 1'b1;
                    if (restore_valid) begin
                        restore = 1'b1;
                        error_d = 1'b0;
                    end else if (depth_w != '0) begin
                        pop     = 1'b1;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (bus.op_pulse) begin
                    accepted = 1'b1;
                    if (depth_w < DW'(2)) begin
                        error_d = 1'b1;
                    end else begin
                        op_latch = 1'b1;
                        error_d  = 1'b0;
                        state_d  = ST_LOAD_A;
                    end
                end else if (bus.enter_pulse) begin
                    accepted = 1'b1;
                    if (depth_w < DW'(DEPTH)) begin
                        push    = 1'b1;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOAD_A: begin
                alu_data_w = rd_second;
                la         = 1'b1;
                state_d    = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                alu_data_w = rd_top;
                lb         = 1'b1;
                state_d    = ST_LOAD_OP;
            end
            ST_LOAD_OP: begin
                alu_data_w = W'(op_q);
                lo         = 1'b1;
                state_d    = ST_EXEC;
            end
            ST_EXEC: begin
                ur      = 1'b1;
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                wr_second = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched opcode and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (op_latch) op_q <= bus.op_in;
        end
    end

`ifdef UNDO_RESTORE_EN
    // Keep the consumed operands so the next undo can put them back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_a      <= '0;
            shadow_b      <= '0;
            restore_valid <= 1'b0;
        end else if (state_q == ST_WRITEBACK) begin
            shadow_a      <= rd_second;
            shadow_b      <= rd_top;
            restore_valid <= 1'b1;
        end else if (accepted) begin
            restore_valid <= 1'b0;
        end
    end
`else
    assign shadow_a      = '0;
    assign shadow_b      = '0;
    assign restore_valid = 1'b0;
`endif

    assign bus.alu_data  = alu_data_w;
    assign bus.load_A    = la;
    assign bus.load_B    = lb;
    assign bus.load_Op   = lo;
    assign bus.updateRes = ur;
    assign bus.top       = top_w;
    assign bus.depth     = depth_w;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.error     = error_q;
    assign bus.Status    = state_q;

endmodule
